fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: a PC register, a program memory with a load port, and
// registered instruction/PC outputs with one-bubble branch flush and stall hold.
module fetch_unit #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              be,
  input  logic [ADDR_W-1:0] branch_adr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_adr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] iout,
  output logic [ADDR_W-1:0] pc_out,
  output logic              valid
);

  localparam int                DEPTH      = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] iout_q, iout_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic              valid_q, valid_d;

  // The write lands via NBA, so a same-cycle fetch still sees the old word.
  assign rd_data = mem_q[pc_q];

  // Next-state: stall freezes everything, branch flushes one slot, else fetch.
  always_comb begin
    pc_d     = pc_q;
    iout_d   = iout_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    if (stall) begin
      pc_d     = pc_q;
      iout_d   = iout_q;
      pc_out_d = pc_out_q;
      valid_d  = valid_q;
    end else if (be) begin
      pc_d    = branch_adr;
      valid_d = 1'b0;
    end else begin
      iout_d   = rd_data;
      pc_out_d = pc_q;
      valid_d  = 1'b1;
      pc_d     = pc_q + ADDR_W'(1);
    end
  end

  // Fetch pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC_A;
      iout_q   <= {DATA_W{1'b0}};
      pc_out_q <= {ADDR_W{1'b0}};
      valid_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      iout_q   <= iout_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  // Program-load port; independent of reset, stall and branch.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_adr] <= wr_data;
    end
  end

  assign iout   = iout_q;
  assign pc_out = pc_out_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed vector table, wrap and parameter-variant
// sequences, and randomized traffic against a behavioural model.
module tb_fetch_unit;

  logic        clk;
  logic        rst, stall, be, wr_en;
  logic [3:0]  branch_adr, wr_adr;
  logic [15:0] wr_data;
  logic [15:0] iout;
  logic [3:0]  pc_out;
  logic        valid;

  logic        b_rst, b_stall, b_be, b_wr_en;
  logic [5:0]  b_branch_adr, b_wr_adr;
  logic [31:0] b_wr_data;
  logic [31:0] b_iout;
  logic [5:0]  b_pc_out;
  logic        b_valid;

  int errors = 0;
  int checks = 0;

  // Behavioural model of the default instance
  logic [15:0] m_mem [16];
  int          m_pc;
  logic [15:0] m_iout;
  int          m_pc_out;
  logic        m_valid;

  fetch_unit dut_a (
    .clk(clk), .rst(rst), .stall(stall), .be(be), .branch_adr(branch_adr),
    .wr_en(wr_en), .wr_adr(wr_adr), .wr_data(wr_data),
    .iout(iout), .pc_out(pc_out), .valid(valid)
  );

  fetch_unit #(.DATA_W(32), .ADDR_W(6), .RESET_PC(7)) dut_b (
    .clk(clk), .rst(b_rst), .stall(b_stall), .be(b_be), .branch_adr(b_branch_adr),
    .wr_en(b_wr_en), .wr_adr(b_wr_adr), .wr_data(b_wr_data),
    .iout(b_iout), .pc_out(b_pc_out), .valid(b_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, be;
    logic [3:0]  badr;
    logic        wr;
    logic [3:0]  wadr;
    logic [15:0] wdata;
    logic [15:0] e_iout;
    logic [3:0]  e_pc;
    logic        e_valid;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic s, logic b, logic [3:0] ba, logic w,
                              logic [3:0] wa, logic [15:0] wd, logic [15:0] ei,
                              logic [3:0] ep, logic ev);
    vec_t v;
    v.rst = r; v.stall = s; v.be = b; v.badr = ba; v.wr = w; v.wadr = wa;
    v.wdata = wd; v.e_iout = ei; v.e_pc = ep; v.e_valid = ev;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: advance the model using the current inputs, then sample #1 after the edge.
  task automatic cyc();
    if (rst) begin
      m_pc = 0; m_iout = 16'h0000; m_pc_out = 0; m_valid = 1'b0;
    end else if (!stall) begin
      if (be) begin
        m_pc = int'(branch_adr);
        m_valid = 1'b0;
      end else begin
        m_iout   = m_mem[m_pc];
        m_pc_out = m_pc;
        m_valid  = 1'b1;
        m_pc     = (m_pc + 1) % 16;
      end
    end
    if (wr_en) m_mem[wr_adr] = wr_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;
    m_pc = 0; m_iout = 16'h0000; m_pc_out = 0; m_valid = 1'b0;
    rst = 1'b1; stall = 1'b0; be = 1'b0; branch_adr = 4'd0;
    wr_en = 1'b0; wr_adr = 4'd0; wr_data = 16'h0000;
    b_rst = 1'b1; b_stall = 1'b0; b_be = 1'b0; b_branch_adr = 6'd0;
    b_wr_en = 1'b0; b_wr_adr = 6'd0; b_wr_data = 32'h0;

    // Directed table: load under reset, fetch, branch, stall, same-address write, halt, reset
    tbl.push_back(mk(1'b1,1'b0,1'b0,4'd0, 1'b1,4'd0, 16'h0000, 16'h0000,4'd0, 1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,4'd0, 1'b1,4'd1, 16'h1105, 16'h0000,4'd0, 1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,4'd0, 1'b1,4'd2, 16'h1202, 16'h0000,4'd0, 1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,4'd0, 1'b1,4'd3, 16'h0033, 16'h0000,4'd0, 1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,4'd0, 1'b1,4'd4, 16'h0044, 16'h0000,4'd0, 1'b0));
    tbl.push_back(mk(1'b1,1'b1,1'b1,4'd9, 1'b1,4'd12,16'h4234, 16'h0000,4'd0, 1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b1,4'd5, 1'b1,4'd13,16'h00DD, 16'h0000,4'd0, 1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,4'd0, 1'b0,4'd0, 16'h0000, 16'h0000,4'd0, 1'b1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,4'd0, 1'b0,4'd0, 16'h0000, 16'h1105,4'd1, 1'b1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,4'd0, 1'b0,4'd0, 16'h0000, 16'h1202,4'd2, 1'b1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,4'd0, 1'b1,4'd3, 16'hBEEF, 16'h0033,4'd3, 1'b1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,4'd0, 1'b0,4'd0, 16'h0000, 16'h0044,4'd4, 1'b1));
    tbl.push_back(mk(1'b0,1'b0,1'b1,4'd12,1'b0,4'd0, 16'h0000, 16'h0044,4'd4, 1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,4'd0, 1'b0,4'd0, 16'h0000, 16'h4234,4'd12,1'b1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1'b0,1'b1,1'b1,4'd9, 1'b0,4'd0, 16'h0000, 16'h4234,4'd12,1'b1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,4'd0, 1'b0,4'd0, 16'h0000, 16'h00DD,4'd13,1'b1));
    tbl.push_back(mk(1'b0,1'b0,1'b1,4'd3, 1'b0,4'd0, 16'h0000, 16'h00DD,4'd13,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,4'd0, 1'b0,4'd0, 16'h0000, 16'hBEEF,4'd3, 1'b1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1'b0,1'b0,1'b1,4'd4, 1'b0,4'd0, 16'h0000, 16'hBEEF,4'd3, 1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,4'd0, 1'b0,4'd0, 16'h0000, 16'h0044,4'd4, 1'b1));
    tbl.push_back(mk(1'b1,1'b0,1'b1,4'd9, 1'b0,4'd0, 16'h0000, 16'h0000,4'd0, 1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,4'd0, 1'b0,4'd0, 16'h0000, 16'h0000,4'd0, 1'b1));
    tbl.push_back(mk(1'b1,1'b1,1'b0,4'd0, 1'b0,4'd0, 16'h0000, 16'h0000,4'd0, 1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,4'd0, 1'b0,4'd0, 16'h0000, 16'h0000,4'd0, 1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,4'd0, 1'b0,4'd0, 16'h0000, 16'h0000,4'd0, 1'b1));

    foreach (tbl[k]) begin
      rst = tbl[k].rst; stall = tbl[k].stall; be = tbl[k].be; branch_adr = tbl[k].badr;
      wr_en = tbl[k].wr; wr_adr = tbl[k].wadr; wr_data = tbl[k].wdata;
      cyc();
      chk($sformatf("tbl[%0d].iout", k),   64'(iout),   64'(tbl[k].e_iout));
      chk($sformatf("tbl[%0d].pc_out", k), 64'(pc_out), 64'(tbl[k].e_pc));
      chk($sformatf("tbl[%0d].valid", k),  64'(valid),  64'(tbl[k].e_valid));
    end

    // PC wrap: 16 sequential fetches from reset, then back to 0
    rst = 1'b1; stall = 1'b0; be = 1'b0; wr_en = 1'b0;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk($sformatf("wrap.pc_out[%0d]", i), 64'(pc_out), 64'(i));
      chk($sformatf("wrap.valid[%0d]", i),  64'(valid),  64'd1);
    end
    cyc();
    chk("wrap.pc_out_after", 64'(pc_out), 64'd0);
    chk("wrap.valid_after",  64'(valid),  64'd1);

    // Parameter variant: RESET_PC=7, 32-bit data, 6-bit address
    b_wr_en = 1'b1; b_wr_adr = 6'd7; b_wr_data = 32'hCAFE_0007;
    cyc();
    chk("b.rst.iout", 64'(b_iout), 64'd0);
    chk("b.rst.pc_out", 64'(b_pc_out), 64'd0);
    chk("b.rst.valid", 64'(b_valid), 64'd0);
    b_wr_adr = 6'd8; b_wr_data = 32'h1234_5678;
    cyc();
    b_wr_en = 1'b0; b_rst = 1'b0;
    cyc();
    chk("b.first.pc_out", 64'(b_pc_out), 64'd7);
    chk("b.first.iout",   64'(b_iout),   64'hCAFE_0007);
    chk("b.first.valid",  64'(b_valid),  64'd1);
    b_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("b.stall.pc_out", 64'(b_pc_out), 64'd7);
      chk("b.stall.valid",  64'(b_valid),  64'd1);
    end
    b_rst = 1'b1;
    cyc();
    chk("b.rst_stall.pc_out", 64'(b_pc_out), 64'd0);
    chk("b.rst_stall.valid",  64'(b_valid),  64'd0);
    chk("b.rst_stall.iout",   64'(b_iout),   64'd0);
    b_rst = 1'b0; b_stall = 1'b0;
    cyc();
    chk("b.refetch.pc_out", 64'(b_pc_out), 64'd7);
    chk("b.refetch.iout",   64'(b_iout),   64'hCAFE_0007);
    chk("b.refetch.valid",  64'(b_valid),  64'd1);
    b_be = 1'b1; b_branch_adr = 6'd8;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("b.halt.valid",  64'(b_valid),  64'd0);
      chk("b.halt.pc_out", 64'(b_pc_out), 64'd7);
    end
    b_be = 1'b0;
    cyc();
    chk("b.resume.pc_out", 64'(b_pc_out), 64'd8);
    chk("b.resume.iout",   64'(b_iout),   64'h1234_5678);
    chk("b.resume.valid",  64'(b_valid),  64'd1);

    // Randomized traffic against the model; start with a random program load under reset
    rst = 1'b1; stall = 1'b0; be = 1'b0; wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_adr = 4'(i); wr_data = 16'($urandom);
      cyc();
    end
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 29) == 0);
      stall      = ($urandom_range(0, 4) == 0);
      be         = ($urandom_range(0, 5) == 0);
      branch_adr = ($urandom_range(0, 3) == 0) ? 4'(m_pc) : 4'($urandom);
      wr_en      = ($urandom_range(0, 2) == 0);
      wr_adr     = 4'($urandom);
      wr_data    = 16'($urandom);
      cyc();
      chk($sformatf("rand[%0d].iout", i),   64'(iout),   64'(m_iout));
      chk($sformatf("rand[%0d].pc_out", i), 64'(pc_out), 64'(m_pc_out));
      chk($sformatf("rand[%0d].valid", i),  64'(valid),  64'(m_valid));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
